// File: rtl/bus_unit_if.sv
// External memory port of bus_unit. The master side issues held-valid beats.
// The slave side answers each beat with ext_ready and read data.
interface bus_unit_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  ext_valid;
    logic                  ext_instruction;
    logic                  ext_ready;
    logic [ADDR_WIDTH-1:0] ext_address;
    logic [31:0]           ext_write_data;
    logic [3:0]            ext_write_strobe;
    logic [31:0]           ext_read_data;

    modport master (
        output ext_valid, ext_instruction, ext_address, ext_write_data, ext_write_strobe,
        input  ext_ready, ext_read_data
    );

    modport slave (
        input  ext_valid, ext_instruction, ext_address, ext_write_data, ext_write_strobe,
        output ext_ready, ext_read_data
    );
endinterface

// File: rtl/bus_unit.sv
// Registered, arbitrating bus unit: fetch and load/store share one external memory port.
// Defining BUS_MISALIGNED_EN splits word-crossing accesses into two beats instead of rejecting them.
module bus_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bus_unit_if.master            ext,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic [31:0]           fetch_data,
    output logic                  fetch_ready,
    input  logic                  mem_load,
    input  logic                  mem_store,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_store_data,
    input  logic [1:0]            mem_size,
    input  logic                  mem_signed,
    output logic [31:0]           mem_load_data,
    output logic                  mem_ready,
    output logic                  mem_error
);

`ifdef BUS_MISALIGNED_EN
    localparam bit MISALIGNED_EN = 1'b1;
`else
    localparam bit MISALIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

    // Byte lanes of the access across two consecutive words: [3:0] beat 0, [7:4] beat 1.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'b0000_0001;
            2'd1:    base = 8'b0000_0011;
            default: base = 8'b0000_1111;
        endcase
        return base << off;
    endfunction

    function automatic logic [31:0] extend_load(input logic [63:0] beats, input logic [1:0] off,
                                                input logic [1:0] size, input logic sext);
        logic [31:0] lane;
        logic [31:0] result;
        lane = 32'(beats >> {off, 3'b000});
        case (size)
            2'd0:    result = sext ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
            2'd1:    result = sext ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
            default: result = lane;
        endcase
        return result;
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [31:0]           store_data_q, store_data_d;
    logic [3:0]            strobe_hi_q, strobe_hi_d;
    logic                  is_fetch_q, is_fetch_d;
    logic                  split_q, split_d;
    logic                  last_grant_mem_q, last_grant_mem_d;
    logic [31:0]           beat0_q, beat0_d;
    logic                  ext_valid_q, ext_valid_d;
    logic                  ext_instruction_q, ext_instruction_d;
    logic [ADDR_WIDTH-1:0] ext_address_q, ext_address_d;
    logic [31:0]           ext_write_data_q, ext_write_data_d;
    logic [3:0]            ext_write_strobe_q, ext_write_strobe_d;
    logic                  fetch_ready_q, fetch_ready_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  mem_error_q, mem_error_d;
    logic [31:0]           mem_load_data_q, mem_load_data_d;

    logic       grant_mem;
    logic       reject;
    logic [7:0] mask_in;

    always_comb begin
        grant_mem = (mem_load | mem_store) &&
                    (!fetch_valid || ARB_MODE == 0 || !last_grant_mem_q);
        mask_in   = lane_mask(mem_size, mem_address[1:0]);
        reject    = (mem_size == 2'd3) ||
                    (!MISALIGNED_EN && ((mem_size == 2'd1 && mem_address[0]) ||
                                        (mem_size == 2'd2 && mem_address[1:0] != 2'd0)));
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        size_d             = size_q;
        signed_d           = signed_q;
        store_data_d       = store_data_q;
        strobe_hi_d        = strobe_hi_q;
        is_fetch_d         = is_fetch_q;
        split_d            = split_q;
        last_grant_mem_d   = last_grant_mem_q;
        beat0_d            = beat0_q;
        ext_valid_d        = ext_valid_q;
        ext_instruction_d  = ext_instruction_q;
        ext_address_d      = ext_address_q;
        ext_write_data_d   = ext_write_data_q;
        ext_write_strobe_d = ext_write_strobe_q;
        mem_load_data_d    = mem_load_data_q;
        fetch_ready_d      = 1'b0;
        mem_ready_d        = 1'b0;
        mem_error_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    last_grant_mem_d = 1'b1;
                    is_fetch_d       = 1'b0;
                    addr_d           = mem_address;
                    size_d           = mem_size;
                    signed_d         = mem_signed;
                    store_data_d     = mem_store ? mem_store_data : 32'h0;
                    if (reject) begin
                        state_d         = RESP;
                        mem_ready_d     = 1'b1;
                        mem_error_d     = 1'b1;
                        mem_load_data_d = 32'h0;
                    end else begin
                        state_d            = BEAT0;
                        ext_valid_d        = 1'b1;
                        ext_instruction_d  = 1'b0;
                        ext_address_d      = {mem_address[ADDR_WIDTH-1:2], 2'b00};
                        ext_write_strobe_d = mem_store ? mask_in[3:0] : 4'h0;
                        ext_write_data_d   = mem_store ? mem_store_data << {mem_address[1:0], 3'b000} : 32'h0;
                        strobe_hi_d        = mem_store ? mask_in[7:4] : 4'h0;
                        split_d            = MISALIGNED_EN && (mask_in[7:4] != 4'h0);
                    end
                end else if (fetch_valid) begin
                    last_grant_mem_d   = 1'b0;
                    is_fetch_d         = 1'b1;
                    split_d            = 1'b0;
                    state_d            = BEAT0;
                    ext_valid_d        = 1'b1;
                    ext_instruction_d  = 1'b1;
                    ext_address_d      = fetch_address & ~ADDR_WIDTH'(3);
                    ext_write_strobe_d = 4'h0;
                    ext_write_data_d   = 32'h0;
                end
            end
            BEAT0: begin
                if (ext.ext_ready) begin
                    beat0_d = ext.ext_read_data;
                    if (split_q) begin
                        state_d            = BEAT1;
                        ext_address_d      = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
                        ext_write_strobe_d = strobe_hi_q;
                        ext_write_data_d   = store_data_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});
                    end else begin
                        state_d            = RESP;
                        ext_valid_d        = 1'b0;
                        ext_instruction_d  = 1'b0;
                        ext_write_strobe_d = 4'h0;
                        ext_write_data_d   = 32'h0;
                        if (is_fetch_q) begin
                            fetch_ready_d = 1'b1;
                        end else begin
                            mem_ready_d     = 1'b1;
                            mem_load_data_d = extend_load({32'h0, ext.ext_read_data}, addr_q[1:0],
                                                          size_q, signed_q);
                        end
                    end
                end
            end
`ifdef BUS_MISALIGNED_EN
            BEAT1: begin
                if (ext.ext_ready) begin
                    state_d            = RESP;
                    ext_valid_d        = 1'b0;
                    ext_write_strobe_d = 4'h0;
                    ext_write_data_d   = 32'h0;
                    mem_ready_d        = 1'b1;
                    mem_load_data_d    = extend_load({ext.ext_read_data, beat0_q}, addr_q[1:0],
                                                     size_q, signed_q);
                end
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q            <= IDLE;
            addr_q             <= '0;
            size_q             <= 2'd0;
            signed_q           <= 1'b0;
            store_data_q       <= 32'h0;
            strobe_hi_q        <= 4'h0;
            is_fetch_q         <= 1'b0;
            split_q            <= 1'b0;
            last_grant_mem_q   <= 1'b0;
            beat0_q            <= 32'h0;
            ext_valid_q        <= 1'b0;
            ext_instruction_q  <= 1'b0;
            ext_address_q      <= '0;
            ext_write_data_q   <= 32'h0;
            ext_write_strobe_q <= 4'h0;
            fetch_ready_q      <= 1'b0;
            mem_ready_q        <= 1'b0;
            mem_error_q        <= 1'b0;
            mem_load_data_q    <= 32'h0;
        end else begin
            state_q            <= state_d;
            addr_q             <= addr_d;
            size_q             <= size_d;
            signed_q           <= signed_d;
            store_data_q       <= store_data_d;
            strobe_hi_q        <= strobe_hi_d;
            is_fetch_q         <= is_fetch_d;
            split_q            <= split_d;
            last_grant_mem_q   <= last_grant_mem_d;
            beat0_q            <= beat0_d;
            ext_valid_q        <= ext_valid_d;
            ext_instruction_q  <= ext_instruction_d;
            ext_address_q      <= ext_address_d;
            ext_write_data_q   <= ext_write_data_d;
            ext_write_strobe_q <= ext_write_strobe_d;
            fetch_ready_q      <= fetch_ready_d;
            mem_ready_q        <= mem_ready_d;
            mem_error_q        <= mem_error_d;
            mem_load_data_q    <= mem_load_data_d;
        end
    end

    assign ext.ext_valid        = ext_valid_q;
    assign ext.ext_instruction  = ext_instruction_q;
    assign ext.ext_address      = ext_address_q;
    assign ext.ext_write_data   = ext_write_data_q;
    assign ext.ext_write_strobe = ext_write_strobe_q;
    assign fetch_data           = beat0_q;
    assign fetch_ready          = fetch_ready_q;
    assign mem_load_data        = mem_load_data_q;
    assign mem_ready            = mem_ready_q;
    assign mem_error            = mem_error_q;

endmodule

// File: tb/tb_bus_unit.sv
// Scoreboard bench for bus_unit: directed requests push expected responses, a monitor pops on each ready pulse.
// A second instance with ARB_MODE=0 shares the stimulus to check fixed-priority arbitration.
module tb_bus_unit;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bus_unit_if #(.ADDR_WIDTH(AW)) bus ();
    bus_unit_if #(.ADDR_WIDTH(AW)) bus0 ();

    logic          fetch_valid;
    logic [AW-1:0] fetch_address;
    logic          mem_load, mem_store, mem_signed;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_store_data;
    logic [1:0]    mem_size;
    logic [31:0]   fetch_data, mem_load_data, f0_data, m0_data;
    logic          fetch_ready, mem_ready, mem_error, f0_ready, m0_ready, m0_error;

    logic        ext_ready_r = 1'b0;
    logic [31:0] ext_read_data_r = 32'h0;
    assign bus.ext_ready      = ext_ready_r;
    assign bus.ext_read_data  = ext_read_data_r;
    assign bus0.ext_ready     = ext_ready_r;
    assign bus0.ext_read_data = ext_read_data_r;

    bus_unit #(.ADDR_WIDTH(AW), .ARB_MODE(1)) dut (
        .clk(clk), .reset_n(reset_n), .ext(bus),
        .fetch_valid(fetch_valid), .fetch_address(fetch_address),
        .fetch_data(fetch_data), .fetch_ready(fetch_ready),
        .mem_load(mem_load), .mem_store(mem_store), .mem_address(mem_address),
        .mem_store_data(mem_store_data), .mem_size(mem_size), .mem_signed(mem_signed),
        .mem_load_data(mem_load_data), .mem_ready(mem_ready), .mem_error(mem_error)
    );

    bus_unit #(.ADDR_WIDTH(AW), .ARB_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .ext(bus0),
        .fetch_valid(fetch_valid), .fetch_address(fetch_address),
        .fetch_data(f0_data), .fetch_ready(f0_ready),
        .mem_load(mem_load), .mem_store(mem_store), .mem_address(mem_address),
        .mem_store_data(mem_store_data), .mem_size(mem_size), .mem_signed(mem_signed),
        .mem_load_data(m0_data), .mem_ready(m0_ready), .mem_error(m0_error)
    );

    typedef struct {
        bit          is_fetch;
        bit          chk_data;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          failures = 0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;

    logic        snap_valid [0:63];
    logic        snap_instr [0:63];
    logic [31:0] snap_addr  [0:63];
    logic [3:0]  snap_strobe[0:63];
    logic [31:0] snap_wdata [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input bit is_fetch, input bit chk_data, input logic [31:0] data, input bit err);
        exp_t e;
        e.is_fetch = is_fetch;
        e.chk_data = chk_data;
        e.data     = data;
        e.err      = err;
        sb_q.push_back(e);
    endtask

    task automatic idle_inputs();
        fetch_valid    = 1'b0;
        fetch_address  = '0;
        mem_load       = 1'b0;
        mem_store      = 1'b0;
        mem_address    = '0;
        mem_store_data = 32'h0;
        mem_size       = 2'd0;
        mem_signed     = 1'b0;
    endtask

    task automatic mem_req(input bit store, input logic [AW-1:0] addr, input logic [1:0] size,
                           input bit sgn, input logic [31:0] data);
        mem_load       = !store;
        mem_store      = store;
        mem_address    = addr;
        mem_size       = size;
        mem_signed     = sgn;
        mem_store_data = data;
    endtask

    // Called at a negedge with the DUT idle; returns the cycle index of the ready pulse (-1 on timeout).
    task automatic issue_and_wait(output int lat);
        lat = -1;
        for (int c = 0; c < 64; c++) begin
            snap_valid[c] = 1'b0;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            snap_valid[c]  = bus.ext_valid;
            snap_instr[c]  = bus.ext_instruction;
            snap_addr[c]   = bus.ext_address;
            snap_strobe[c] = bus.ext_write_strobe;
            snap_wdata[c]  = bus.ext_write_data;
            if (fetch_ready === 1'b1 || mem_ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    // External memory model: acknowledges each beat after wait_cfg cycles with the head of rd_q.
    always @(negedge clk) begin
        if (ext_ready_r && rd_q.size() > 0) void'(rd_q.pop_front());
        if (bus.ext_valid === 1'b1) begin
            if (wait_cnt >= wait_cfg) begin
                ext_ready_r     = 1'b1;
                ext_read_data_r = (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_BEEF;
                wait_cnt        = 0;
            end else begin
                ext_ready_r = 1'b0;
                wait_cnt++;
            end
        end else begin
            ext_ready_r = 1'b0;
            wait_cnt    = 0;
        end
    end

    // Monitor: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (fetch_ready === 1'b1 || mem_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: fetch_ready=%0b mem_ready=%0b with nothing outstanding",
                         fetch_ready, mem_ready);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_kind", 32'({fetch_ready, mem_ready}), mon_e.is_fetch ? 32'h2 : 32'h1);
                if (mon_e.is_fetch) begin
                    check("sb_fetch_data", fetch_data, mon_e.data);
                end else begin
                    check("sb_mem_error", 32'(mem_error), 32'(mon_e.err));
                    if (mon_e.chk_data) check("sb_load_data", mem_load_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int n0;
        int pulse_cyc[0:2];
        logic [2:0] grant0_mem;

        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ext_valid", 32'(bus.ext_valid), 32'h0);
        check("rst_ext_strobe", 32'(bus.ext_write_strobe), 32'h0);
        check("rst_ext_address", bus.ext_address, 32'h0);
        check("rst_ext_wdata", bus.ext_write_data, 32'h0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'h0);
        check("rst_mem_error", 32'(mem_error), 32'h0);
        check("rst_fetch_data", fetch_data, 32'h0);
        check("rst_load_data", mem_load_data, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Aligned fetch, zero-wait.
        fetch_valid = 1'b1; fetch_address = 32'h104;
        rd_q.push_back(32'h0000_0013);
        expect_rsp(1'b1, 1'b1, 32'h0000_0013, 1'b0);
        issue_and_wait(lat);
        check("fetch_addr_c1", snap_addr[1], 32'h104);
        check("fetch_instr_c1", 32'(snap_instr[1]), 32'h1);
        check("fetch_latency", 32'(lat), 32'd2);

        // Signed and unsigned byte loads at offset 3.
        mem_req(1'b0, 32'h203, 2'd0, 1'b1, 32'h0);
        rd_q.push_back(32'h80FF_0000);
        expect_rsp(1'b0, 1'b1, 32'hFFFF_FF80, 1'b0);
        issue_and_wait(lat);
        check("lb_addr_c1", snap_addr[1], 32'h200);
        check("lb_strobe_c1", 32'(snap_strobe[1]), 32'h0);
        check("lb_latency", 32'(lat), 32'd2);
        mem_req(1'b0, 32'h203, 2'd0, 1'b0, 32'h0);
        rd_q.push_back(32'h80FF_0000);
        expect_rsp(1'b0, 1'b1, 32'h0000_0080, 1'b0);
        issue_and_wait(lat);

        // Halfword store with two wait cycles.
        wait_cfg = 2;
        mem_req(1'b1, 32'h302, 2'd1, 1'b0, 32'h0000_BEEF);
        expect_rsp(1'b0, 1'b0, 32'h0, 1'b0);
        issue_and_wait(lat);
        for (int c = 1; c <= 3; c++) begin
            check("sh_valid_held", 32'(snap_valid[c]), 32'h1);
            check("sh_strobe_held", 32'(snap_strobe[c]), 32'hC);
            check("sh_wdata_held", snap_wdata[c], 32'hBEEF_0000);
        end
        check("sh_latency", 32'(lat), 32'd4);
        wait_cfg = 0;

        // Word load crossing a word boundary.
        mem_req(1'b0, 32'h401, 2'd2, 1'b0, 32'h0);
`ifdef BUS_MISALIGNED_EN
        rd_q.push_back(32'h4433_2211);
        rd_q.push_back(32'h8877_6655);
        expect_rsp(1'b0, 1'b1, 32'h5544_3322, 1'b0);
        issue_and_wait(lat);
        check("lw_mis_addr_b0", snap_addr[1], 32'h400);
        check("lw_mis_addr_b1", snap_addr[2], 32'h404);
        check("lw_mis_valid_b1", 32'(snap_valid[2]), 32'h1);
        check("lw_mis_latency", 32'(lat), 32'd3);
`else
        expect_rsp(1'b0, 1'b1, 32'h0, 1'b1);
        issue_and_wait(lat);
        check("lw_mis_no_beat", 32'(snap_valid[1]), 32'h0);
        check("lw_mis_latency", 32'(lat), 32'd1);
`endif

        // Halfword at offset 1.
        mem_req(1'b0, 32'h301, 2'd1, 1'b0, 32'h0);
`ifdef BUS_MISALIGNED_EN
        rd_q.push_back(32'hAABB_CCDD);
        expect_rsp(1'b0, 1'b1, 32'h0000_BBCC, 1'b0);
        issue_and_wait(lat);
        check("lh_off1_latency", 32'(lat), 32'd2);
`else
        expect_rsp(1'b0, 1'b1, 32'h0, 1'b1);
        issue_and_wait(lat);
        check("lh_off1_latency", 32'(lat), 32'd1);
`endif

        // Illegal size is always rejected without a beat.
        mem_req(1'b0, 32'h500, 2'd3, 1'b0, 32'h0);
        expect_rsp(1'b0, 1'b1, 32'h0, 1'b1);
        issue_and_wait(lat);
        check("size3_no_beat", 32'(snap_valid[1]), 32'h0);
        check("size3_latency", 32'(lat), 32'd1);

        // Reset during a stalled beat abandons it silently.
        wait_cfg = 100;
        fetch_valid = 1'b1; fetch_address = 32'h700;
        @(negedge clk);
        check("abort_valid_before", 32'(bus.ext_valid), 32'h1);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("abort_valid_after", 32'(bus.ext_valid), 32'h0);
        check("abort_no_ready", 32'({fetch_ready, mem_ready}), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cfg = 0;
        repeat (3) @(negedge clk);
        check("abort_still_idle", 32'(bus.ext_valid), 32'h0);
        fetch_valid = 1'b1; fetch_address = 32'h104;
        rd_q.push_back(32'h0000_1234);
        expect_rsp(1'b1, 1'b1, 32'h0000_1234, 1'b0);
        issue_and_wait(lat);
        check("refetch_latency", 32'(lat), 32'd2);

        // Both sides pending: round-robin on dut, memory priority on dut0.
        fetch_valid = 1'b1; fetch_address = 32'h600;
        mem_req(1'b0, 32'h500, 2'd2, 1'b0, 32'h0);
        rd_q.push_back(32'h0000_00A1);
        rd_q.push_back(32'h0000_00B2);
        rd_q.push_back(32'h0000_00C3);
        expect_rsp(1'b0, 1'b1, 32'h0000_00A1, 1'b0);
        expect_rsp(1'b1, 1'b1, 32'h0000_00B2, 1'b0);
        expect_rsp(1'b0, 1'b1, 32'h0000_00C3, 1'b0);
        n = 0;
        n0 = 0;
        grant0_mem = 3'b000;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (n0 < 3 && (m0_ready === 1'b1 || f0_ready === 1'b1)) begin
                grant0_mem[n0] = m0_ready;
                n0++;
            end
            if (fetch_ready === 1'b1 || mem_ready === 1'b1) begin
                pulse_cyc[n] = c;
                n++;
                if (n == 3) break;
            end
        end
        idle_inputs();
        @(negedge clk);
        check("arb_pulses", 32'(n), 32'd3);
        check("arb_issue_interval", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd3);
        check("arb0_grants_mem", 32'(grant0_mem), 32'h7);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_unit.md
# bus_unit

Registered, arbitrating bus interface unit between the core's fetch and memory stages and the single external memory port. Accepts one fetch or load/store request at a time, drives a held-valid external transaction, and returns data through one-cycle ready pulses. Handles byte/halfword/word access with sign extension. Optionally splits word-crossing misaligned accesses into two bus beats.

## Interface
- `ADDR_WIDTH`, default 32: width of every address port; bits [1:0] are the byte offset.
- `ARB_MODE`, default 0: 0 = memory always wins over fetch; 1 = round-robin between memory and fetch when both are pending.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ext_valid` out 1: external request valid, held until `ext_ready`.
- `ext_instruction` out 1: 1 = current beat is an instruction fetch.
- `ext_ready` in 1: external beat complete this cycle; read data valid.
- `ext_address` out ADDR_WIDTH: word address; bits [1:0] always 0.
- `ext_write_data` out 32: store data, lane-aligned.
- `ext_write_strobe` out 4: byte enables; 0 for reads.
- `ext_read_data` in 32: read data.
- `fetch_valid` in 1: fetch request.
- `fetch_address` in ADDR_WIDTH: fetch address; bits [1:0] ignored.
- `fetch_data` out 32: instruction word, valid with `fetch_ready`.
- `fetch_ready` out 1: one-cycle completion pulse.
- `mem_load`, `mem_store` in 1 each: memory request, never both set.
- `mem_address` in ADDR_WIDTH: byte address.
- `mem_store_data` in 32: store data, LSB-aligned.
- `mem_size` in 2: 0 byte, 1 half, 2 word, 3 illegal.
- `mem_signed` in 1: sign-extend loads.
- `mem_load_data` out 32: extended load data, valid with `mem_ready`.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_error` out 1: valid with `mem_ready`; 1 = access rejected, no bus beat issued.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: if a request is pending, capture address, size, sign, data and kind into registers, then go to BEAT0. If the access is rejected, go directly to RESP with the error flag set. If nothing is pending, stay in IDLE.
- Arbitration:
  - ARB_MODE 0: memory request beats fetch.
  - ARB_MODE 1: a one-bit last-grant register picks the side not granted last time when both are pending. It updates on every grant and resets to "fetch".
- BEAT0/BEAT1: `ext_valid`=1, with address, strobe and data driven from registers only, stable until `ext_ready`.
  - On `ext_ready` in BEAT0: capture `ext_read_data`, then go to BEAT1 if split, otherwise RESP.
  - On `ext_ready` in BEAT1: capture the data and go to RESP.
- RESP: pulse `fetch_ready` or `mem_ready` for exactly one cycle, then return to IDLE. No request is accepted in RESP. The requester drops its request at the edge ending RESP.
- Strobes:
  - Byte: `0001<<off`.
  - Half: `0011<<off`, truncated to 4 bits in beat 0; beat 1 gets the carried-out bits.
  - Word: `1111<<off`, split the same way.
  - Write data is `mem_store_data<<(off*8)` for beat 0 and `mem_store_data>>((4-off)*8)` for beat 1.
- Load data: take `{beat1,beat0}>>(off*8)`, then keep the low 8/16/32 bits and sign- or zero-extend per `mem_signed`.
- `mem_size`=3 is always rejected: `mem_error`=1, `mem_load_data`=0.
- `fetch_data` is the captured beat-0 word.

## Timing
- Reset values: state IDLE, `ext_valid`=0, `ext_write_strobe`=0, `ext_address`=0, `fetch_ready`=0, `mem_ready`=0, `mem_error`=0, data outputs 0, arbitration pointer = fetch.
- Latency:
  - Request sampled at edge E0; `ext_valid` high from cycle 1.
  - With zero-wait `ext_ready`, the ready pulse is in cycle 2 for a single-beat access and cycle 3 for a split access.
  - A rejected access pulses ready in cycle 1.
- Back-to-back: the next request is sampled at the IDLE edge following RESP. Minimum issue interval is 3 cycles.
- `ext_ready` is ignored outside BEAT0/BEAT1.
- Requester inputs are don't-care after capture until RESP.
- Reset asserted mid-transaction: IDLE at the next edge, `ext_valid` deasserts, the beat is abandoned, and no ready pulse is issued.

## Configuration
- `BUS_MISALIGNED_EN` defined:
  - Accesses with `off+bytes>4` become two beats, to address and address+4 (wrapping modulo 2^ADDR_WIDTH).
  - A halfword at offset 1 is one beat with strobe `0110`.
  - `mem_error` is never set for alignment.
- Not defined:
  - Any access with an unaligned offset for its size (half with `off[0]`=1, word with `off`≠0) is rejected: `mem_error`=1, load data 0, no bus beat.
  - State BEAT1 is unreachable and may be removed.

## Test plan
- Fetch at 0x104 with `ext_ready` tied high and read data 0x00000013 -> `ext_address`=0x104 in cycle 1; `fetch_ready`=1 and `fetch_data`=0x00000013 in cycle 2.
- Signed byte load at 0x203 with read data 0x80FF_0000 -> strobe 0, `mem_load_data`=0xFFFFFF80; the unsigned load gives 0x00000080.
- Store half 0xBEEF at 0x302 with 2 wait cycles -> `ext_write_strobe`=1100 and `ext_write_data`=0xBEEF0000 held for 3 cycles; `mem_ready` fires 1 cycle after `ext_ready`.
- `fetch_valid` and `mem_load` both held high, ARB_MODE=1 -> grants alternate: mem, fetch, mem. With ARB_MODE=0 -> mem first.
- Word load at 0x401 with beat data 0x44332211 then 0x88776655:
  - With `BUS_MISALIGNED_EN` -> beats to 0x400 and 0x404, `mem_load_data`=0x55443322.
  - Without it -> no beat, `mem_error`=1 in cycle 1.
- `reset_n` low during BEAT0 with `ext_ready`=0 -> `ext_valid`=0 next cycle, no ready pulse, and a fresh fetch then completes normally.
